hex_display_scan: RTL
=====================

Name: hex_display_scan

Overview:
Downstream consumer of the multicycle MIPS top's debug outputs (PCNext, DispRegData, DispMemData) on the FPGA board. It snapshots one selected 32-bit word per display frame and time-multiplexes it as 8 hex digits onto a common-anode 7-segment display. All outputs are registered, and a frame only changes at a frame boundary, so the display never tears while the CPU single-steps.

Parameters:
DIGITS, 8, number of hex digits scanned; must be 8 for a 32-bit word, other values are unsupported.
PRESCALE, 50000, CLK cycles per digit slot; legal range 1..2^20; 1 means a tick every cycle.

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset (Reset==0 at a rising CLK edge resets)
Sel  in  2  source select: 0=Src0 (PCNext), 1=Src1 (DispRegData), 2=Src2 (DispMemData), 3=constant 32'h0000_0000
Src0  in  32  display source 0
Src1  in  32  display source 1
Src2  in  32  display source 2
Freeze  in  1  1 = keep current snapshot at frame boundaries
An  out  8  digit enables, active-low, one-hot; An[i] drives digit i (i=0 is least significant)
Seg  out  7  segments {g,f,e,d,c,b,a}, active-low
FrameDone  out  1  one-cycle pulse on the edge that starts a new frame
DigitIdx  out  3  index of the digit currently driven

Behaviour:
- Reset (Reset==0 at an edge): prescale cnt=0, idx=DIGITS-1, Snap=32'h0, An=8'hFF (all off), Seg=7'h7F, FrameDone=0, DigitIdx=7. Reset is honoured mid-frame and overrides tick, Freeze and Sel.
- Prescaler: cnt counts 0..PRESCALE-1 and wraps to 0. tick=1 on the cycle where cnt==PRESCALE-1. The first tick arrives PRESCALE cycles after reset is released.
- On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1. On the same edge, An, Seg and DigitIdx are registered for the new idx. No output changes between ticks.
- Frame boundary: a tick with idx==DIGITS-1.
  - If Freeze==0, Snap <= selected source, sampled on that edge.
  - If Freeze==1, Snap holds.
  - FrameDone=1 for exactly that one cycle in both cases.
  - Digit 0 shown at the boundary uses the newly loaded Snap value (the next-value path feeds the decoder).
- Sel and Src changes mid-frame have no visible effect until the next frame boundary.
- Digit data: nibble = Snap[4*idx+3 : 4*idx]. An = ~(8'b1 << idx).
- Seg encoding (active-low, {g..a}), values 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Latency: source sample to first digit visible = 0 cycles after the boundary edge. Full frame = DIGITS*PRESCALE cycles.
- After reset the first tick moves idx 7→0. It is therefore a frame boundary, so the first frame shows the live source immediately.

Optional Feature:
Macro HEX_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - For digit i>0, if Snap[31:4*i]==0, An stays 8'hFF and Seg=7'h7F for that slot. Timing is unchanged.
  - Digit 0 is always shown, so the value 0 displays a single "0".
- Undefined: all 8 digits are always driven, and behaviour is exactly as above.

Test Plan:
1. Bench uses PRESCALE=4. Hold Reset=0 for 3 cycles, then release → An=FF, Seg=7F until cycle 4. On the first tick: FrameDone=1, DigitIdx=0, An=FE.
2. Sel=0, Src0=32'h0123_4567, Freeze=0, run one frame → Seg sequence for digits 0..7: 1111000, 0000010, 0010010, 0011001, 0110000, 0100100, 1111001, 1000000. An sequence: FE, FD, FB, F7, EF, DF, BF, 7F. Digit 0 wraps back after 32 cycles.
3. Mid-frame (idx=3), change Sel 0→2 with Src2=32'hFFFF_FFFF → digits 4..7 still show 3,2,1,0. At the next FrameDone every digit shows F (0001110).
4. Freeze=1, then change Src0 to 32'hA5A5_A5A5 → FrameDone still pulses every 32 cycles and the displayed digits remain 0123_4567. Drop Freeze=0 → the next frame shows A,5 alternating (0001000 / 0010010).
5. Assert Reset=0 for one cycle while idx=5 → next cycle An=FF, Seg=7F, Snap=0, DigitIdx=7. Restart timing is identical to scenario 1.
6. With HEX_DISPLAY_LZ_BLANK_EN, Sel=3 (value 0) → only digit 0 is lit, showing 1000000; slots 1..7 give An=FF. With Src0=32'h0000_0100, digits 0..2 are lit and 3..7 are blank.

Source files
------------

// File: rtl/hex_display_scan.sv
// Snapshots one selected 32-bit debug word per frame and scans it as 8 hex
// digits onto a common-anode 7-segment display. Optional: HEX_DISPLAY_LZ_BLANK_EN.
module hex_display_scan #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  Sel,
  input  logic [31:0] Src0,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  input  logic        Freeze,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        FrameDone,
  output logic [2:0]  DigitIdx
);

  localparam logic [19:0] CNT_LAST = 20'(PRESCALE - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_done_q, frame_done_d;

  logic        tick;
  logic        boundary;
  logic [31:0] sel_word;
  logic [3:0]  nibble;
  logic        blank;

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    cnt_d    = tick ? 20'd0 : cnt_q + 20'd1;
    boundary = tick && (idx_q == IDX_LAST);

    idx_d = idx_q;
    if (tick) idx_d = boundary ? 3'd0 : idx_q + 3'd1;

    case (Sel)
      2'd0:    sel_word = Src0;
      2'd1:    sel_word = Src1;
      2'd2:    sel_word = Src2;
      default: sel_word = 32'h0000_0000;
    endcase

    // Decoder reads the next-value snapshot so digit 0 at a boundary is fresh.
    snap_d = (boundary && !Freeze) ? sel_word : snap_q;
    nibble = snap_d[{idx_d, 2'b00} +: 4];

`ifdef HEX_DISPLAY_LZ_BLANK_EN
    blank = (idx_d != 3'd0) && ((snap_d >> {idx_d, 2'b00}) == 32'h0);
`else
    blank = 1'b0;
`endif

    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = blank ? 8'hFF : ~(8'b1 << idx_d);
      seg_d = blank ? 7'h7F : hex_to_seg(nibble);
    end

    frame_done_d = boundary;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt_q        <= 20'd0;
      idx_q        <= IDX_LAST;
      snap_q       <= 32'h0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign An        = an_q;
  assign Seg       = seg_q;
  assign FrameDone = frame_done_q;
  assign DigitIdx  = idx_q;

endmodule
